strng_reader: RTL



---
 rtl/strng_pkg.sv | 17 +
 rtl/strng_rct.sv | 37 +++
 rtl/strng_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/strng_pkg.sv
// Shared definitions for the STR random number generator consumer side.
package strng_pkg;

  // Reader FSM encoding; kept fixed so software-visible debug taps stay stable.
  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  // Default parameter values for the reader and its health monitors.
  localparam int unsigned RAW_W_DEF     = 8;
  localparam int unsigned OUT_W_DEF     = 32;
  localparam int unsigned WARMUP_DEF    = 64;
  localparam int unsigned RCT_LIMIT_DEF = 32;

endpackage

// File: rtl/strng_rct.sv
// Repetition-count health test: flags a run of LIMIT identical bits.
// The trip is combinational so the owner can react on the same edge that
// counts the LIMIT-th repeat.
module strng_rct
  import strng_pkg::*;
#(
  parameter int unsigned LIMIT = RCT_LIMIT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic fb,
  input  logic en,
  output logic trip
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] run_cnt;
  logic          prev_fb;
  logic          same;

  // A zero count means no bit has been seen yet, so the first bit starts a run.
  assign same = (run_cnt != '0) && (fb == prev_fb);
  assign trip = en && same && (run_cnt == CW'(LIMIT - 1));

  // Track the previous bit and the length of the current run.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_cnt <= '0;
      prev_fb <= 1'b0;
    end else if (en) begin
      prev_fb <= fb;
      run_cnt <= same ? run_cnt + 1'b1 : CW'(1);
    end
  end

endmodule

// File: rtl/strng_reader.sv
// STR TRNG consumer: folds the raw bus to one bit per clock, health-tests it,
// von Neumann debiases it and packs the survivors into OUT_W-bit words
// delivered over valid/ready. An entropy failure latches a sticky alarm.
module strng_reader
  import strng_pkg::*;
#(
  parameter int unsigned RAW_W     = RAW_W_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned WARMUP    = WARMUP_DEF,
  parameter int unsigned RCT_LIMIT = RCT_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [RAW_W-1:0] rnd_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ready_st,
  output logic             alarm
);

  localparam int unsigned WCW = $clog2(WARMUP + 1);
  localparam int unsigned BCW = $clog2(OUT_W);

  state_t           state;
  state_t           state_nx;
  logic [RAW_W-1:0] raw_q;
  logic             raw_vld;
  logic             fb;
  logic             consume;
  logic             trip;
  logic [WCW-1:0]   wu_cnt;
  logic             warm_done;
  logic             phase;
  logic             first_q;
  logic             run_bit;
  logic             emit;
  logic [BCW-1:0]   bit_cnt;
  logic [OUT_W-1:0] word_q;
  logic [OUT_W-1:0] word_nx;
  logic             complete;
  logic             accept;
  logic             load;

  // Input stage: register the raw bus; raw_vld marks that raw_q holds a real sample.
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses <= so all registers see pre-edge values.
    if (!rstn) begin
      raw_q   <= '0;
      raw_vld <= 1'b0;
    end else begin
      raw_q   <= rnd_data;
      raw_vld <= 1'b1;
    end
  end

  assign fb      = ^raw_q;
  assign consume = raw_vld && (state != ST_FAIL);

  strng_rct #(
    .LIMIT (RCT_LIMIT)
  ) u_rct (
    .clk  (clk),
    .rstn (rstn),
    .fb   (fb),
    .en   (consume),
    .trip (trip)
  );

  assign warm_done = consume && (state == ST_WARMUP) && (wu_cnt == WCW'(WARMUP - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_WARMUP;
    else       state <= state_nx;
  end

  // FSM next state: a health trip wins over the warm-up exit.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_WARMUP: if (trip) state_nx = ST_FAIL;
                 else if (warm_done) state_nx = ST_RUN;
      ST_RUN:    if (trip) state_nx = ST_FAIL;
      ST_FAIL:   state_nx = ST_FAIL;
      default:   state_nx = ST_FAIL;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    ready_st = (state == ST_RUN);
    alarm    = (state == ST_FAIL);
  end

  // Warm-up discard counter; it stops once RUN is reached.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wu_cnt <= '0;
    end else if (consume && (state == ST_WARMUP) && !trip) begin
      wu_cnt <= wu_cnt + 1'b1;
    end
  end

  // Corrector: the second bit of a differing pair emits the first bit.
  assign run_bit  = consume && (state == ST_RUN) && !trip;
  assign emit     = run_bit && phase && (first_q != fb);
  assign complete = emit && (bit_cnt == BCW'(OUT_W - 1));
  assign accept   = out_valid && out_ready;
  assign load     = complete && (!out_valid || out_ready);

  // Packer input: the word as it will look with the emitted bit placed at bit_cnt.
  always_comb begin
    word_nx          = word_q;
    word_nx[bit_cnt] = first_q;
  end

  // Corrector phase and packer; a trip clears any partial pair or word.
  always_ff @(posedge clk) begin
    if (!rstn || trip) begin
      phase   <= 1'b0;
      first_q <= 1'b0;
      bit_cnt <= '0;
      word_q  <= '0;
    end else if (run_bit) begin
      phase <= ~phase;
      if (!phase) first_q <= fb;
      if (emit) begin
        word_q  <= word_nx;
        // A completed word restarts the count whether it was loaded or dropped.
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Output register: holds a word until accepted; a trip scrubs it.
  always_ff @(posedge clk) begin
    if (!rstn || trip) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= word_nx;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule
